// File: rtl/keypad_multitap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_multitap
// Purpose  : 4x4 keypad scanner/debouncer with phone-style multi-tap letter entry
// Revision : 1.0  initial release
// ============================================================================
module keypad_multitap #(
    parameter int SCAN_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 5
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] cur_char,
    output logic       char_pending,
    output logic [7:0] letter,
    output logic       letter_strobe,
    output logic       word_strobe
);

    localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCW-1:0] c_SCAN_LAST = SCW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] c_DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]     c_SPACE     = 8'h20;

    typedef enum logic [1:0] {
        S_SCAN       = 2'd0,
        S_DB_PRESS   = 2'd1,
        S_HELD       = 2'd2,
        S_DB_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_sync1, r_sync2;
    logic [3:0]       r_col, r_col_d1, r_col_d2;
    logic [SCW-1:0]   r_scan_cnt;
    logic [DBW-1:0]   r_db_cnt;
    logic [3:0]       r_cap_row;
    logic [7:0]       r_pend_key;
    logic [1:0]       r_tap;
    logic [7:0]       r_cur;
    logic             r_pending;
    logic [7:0]       r_letter;
    logic             r_lstb, r_wstb;

    logic [3:0]       w_rs;
    logic [3:0]       w_rs_onehot;
    logic             w_aligned;
    logic [1:0]       w_ri, w_ci;
    logic [7:0]       w_key_char;
    logic             w_is_letter;
    logic             w_is_four;
    logic [7:0]       w_base;
    logic [1:0]       w_next_tap;

    assign w_rs = r_sync2;
    // rs lags the column drive by the synchroniser depth; only trust it once
    // the delayed column copy matches the column currently driven.
    assign w_aligned = (r_col_d2 == r_col);

    always_comb begin
        w_rs_onehot = 4'b0000;
        if (w_rs[3])      w_rs_onehot = 4'b1000;
        else if (w_rs[2]) w_rs_onehot = 4'b0100;
        else if (w_rs[1]) w_rs_onehot = 4'b0010;
        else if (w_rs[0]) w_rs_onehot = 4'b0001;
    end

    always_comb begin
        w_ri = 2'd0;
        case (r_cap_row)
            4'b0100: w_ri = 2'd1;
            4'b0010: w_ri = 2'd2;
            4'b0001: w_ri = 2'd3;
            default: w_ri = 2'd0;
        endcase
        w_ci = 2'd0;
        case (r_col)
            4'b0100: w_ci = 2'd1;
            4'b0010: w_ci = 2'd2;
            4'b0001: w_ci = 2'd3;
            default: w_ci = 2'd0;
        endcase
    end

    always_comb begin
        w_key_char = 8'h00;
        case ({w_ri, w_ci})
            4'd0:  w_key_char = 8'h31;
            4'd1:  w_key_char = 8'h32;
            4'd2:  w_key_char = 8'h33;
            4'd3:  w_key_char = 8'h41;
            4'd4:  w_key_char = 8'h34;
            4'd5:  w_key_char = 8'h35;
            4'd6:  w_key_char = 8'h36;
            4'd7:  w_key_char = 8'h42;
            4'd8:  w_key_char = 8'h37;
            4'd9:  w_key_char = 8'h38;
            4'd10: w_key_char = 8'h39;
            4'd11: w_key_char = 8'h43;
            4'd12: w_key_char = 8'h2A;
            4'd13: w_key_char = 8'h30;
            4'd14: w_key_char = 8'h23;
            default: w_key_char = 8'h44;
        endcase
    end

    always_comb begin
        w_is_letter = 1'b1;
        w_is_four   = 1'b0;
        w_base      = 8'h00;
        case (w_key_char)
            8'h32: w_base = 8'h41;
            8'h33: w_base = 8'h44;
            8'h34: w_base = 8'h47;
            8'h35: w_base = 8'h4A;
            8'h36: w_base = 8'h4D;
            8'h37: begin w_base = 8'h50; w_is_four = 1'b1; end
            8'h38: w_base = 8'h54;
            8'h39: begin w_base = 8'h57; w_is_four = 1'b1; end
            default: w_is_letter = 1'b0;
        endcase
        w_next_tap = 2'd0;
        if (r_pending && (r_pend_key == w_key_char)) begin
            if (r_tap == (w_is_four ? 2'd3 : 2'd2)) w_next_tap = 2'd0;
            else                                    w_next_tap = r_tap + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (nRst || !enable) begin
            r_state    <= S_SCAN;
            r_col      <= 4'b1000;
            r_col_d1   <= 4'b1000;
            r_col_d2   <= 4'b1000;
            r_scan_cnt <= '0;
            r_db_cnt   <= '0;
            r_cap_row  <= 4'b0000;
            r_pend_key <= 8'h00;
            r_tap      <= 2'd0;
            r_cur      <= c_SPACE;
            r_pending  <= 1'b0;
            r_lstb     <= 1'b0;
            r_wstb     <= 1'b0;
            if (nRst) r_letter <= 8'h00;
        end else begin
            r_lstb   <= 1'b0;
            r_wstb   <= 1'b0;
            r_col_d1 <= r_col;
            r_col_d2 <= r_col_d1;
            case (r_state)
                S_SCAN: begin
                    if (r_scan_cnt == c_SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (w_rs != 4'b0000) begin
                            r_cap_row <= w_rs_onehot;
                            r_col     <= r_col_d2;
                            r_db_cnt  <= '0;
                            r_state   <= S_DB_PRESS;
                        end else begin
                            r_col <= {r_col[0], r_col[3:1]};
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                S_DB_PRESS: begin
                    if (w_aligned) begin
                        if (w_rs != r_cap_row) begin
                            r_state    <= S_SCAN;
                            r_scan_cnt <= '0;
                            r_db_cnt   <= '0;
                        end else if (r_db_cnt != c_DB_LAST) begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end else begin
                            r_state  <= S_HELD;
                            r_db_cnt <= '0;
                            if (w_is_letter) begin
                                r_pend_key <= w_key_char;
                                r_tap      <= w_next_tap;
                                r_cur      <= w_base + {6'd0, w_next_tap};
                                r_pending  <= 1'b1;
                            end else if ((w_key_char == 8'h2A && r_pending) ||
                                         w_key_char == 8'h23 || w_key_char == 8'h30) begin
                                if (w_key_char == 8'h2A) begin
                                    r_letter <= r_cur;
                                    r_lstb   <= 1'b1;
                                end
                                if (w_key_char == 8'h23) r_wstb <= 1'b1;
                                r_pend_key <= 8'h00;
                                r_tap      <= 2'd0;
                                r_cur      <= c_SPACE;
                                r_pending  <= 1'b0;
                            end
                        end
                    end
                end
                S_HELD: begin
                    if (w_rs == 4'b0000) begin
                        r_state  <= S_DB_RELEASE;
                        r_db_cnt <= '0;
                    end
                end
                S_DB_RELEASE: begin
                    if (w_rs != 4'b0000) begin
                        r_state  <= S_HELD;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt != c_DB_LAST) begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end else begin
                        r_state    <= S_SCAN;
                        r_db_cnt   <= '0;
                        r_scan_cnt <= '0;
                        r_col      <= {r_col[0], r_col[3:1]};
                    end
                end
                default: r_state <= S_SCAN;
            endcase
        end
    end

    assign col           = r_col;
    assign cur_char      = r_cur;
    assign char_pending  = r_pending;
    assign letter        = r_letter;
    assign letter_strobe = r_lstb;
    assign word_strobe   = r_wstb;

endmodule
`default_nettype wire

// File: tb/tb_keypad_multitap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_multitap
// Purpose  : keypad_multitap bench with a key-level multi-tap reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_multitap;

    logic       clk = 1'b0;
    logic       nRst, enable;
    logic [3:0] row, col;
    logic [7:0] cur_char, letter;
    logic       char_pending, letter_strobe, word_strobe;

    logic       pressed;
    int         kr, kc;
    logic       force_en;
    logic [3:0] force_val;

    int n_chk = 0;
    int n_pass = 0;
    int lstb_cnt = 0;
    int wstb_cnt = 0;

    logic [7:0] m_key;
    int         m_tap;
    logic [7:0] m_letter;
    int         e_l, e_w;
    string      grp[8] = '{"ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};
    logic [7:0] km[16] = '{"1", "2", "3", "A", "4", "5", "6", "B",
                           "7", "8", "9", "C", "*", "0", "#", "D"};

    keypad_multitap #(.SCAN_CYCLES(2), .DEBOUNCE_CYCLES(5)) dut (
        .clk(clk), .nRst(nRst), .enable(enable), .row(row), .col(col),
        .cur_char(cur_char), .char_pending(char_pending), .letter(letter),
        .letter_strobe(letter_strobe), .word_strobe(word_strobe)
    );

    always #5 clk = ~clk;

    // Physical keypad: the pressed key shorts its row to its column drive.
    always_comb begin
        if (force_en)                      row = force_val;
        else if (pressed && col[3 - kc])   row = 4'b1000 >> kr;
        else                               row = 4'b0000;
    end

    always @(negedge clk) begin
        if (letter_strobe) lstb_cnt++;
        if (word_strobe)   wstb_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_cur();
        if (m_key == 8'h00) return 8'h20;
        return grp[int'(m_key) - 50][m_tap];
    endfunction

    task automatic m_clear();
        m_key = 8'h00;
        m_tap = 0;
    endtask

    task automatic m_apply(input int k);
        logic [7:0] ch;
        ch = km[k];
        if (ch >= "2" && ch <= "9") begin
            if (m_key == ch) m_tap = (m_tap + 1) % grp[int'(ch) - 50].len();
            else begin m_key = ch; m_tap = 0; end
        end else if (ch == "*") begin
            if (m_key != 8'h00) begin m_letter = m_cur(); e_l++; m_clear(); end
        end else if (ch == "#") begin
            e_w++; m_clear();
        end else if (ch == "0") begin
            m_clear();
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".cur_char"}, cur_char, m_cur());
        chk({tag, ".pending"}, char_pending, m_key != 8'h00);
        chk({tag, ".letter"}, letter, m_letter);
        chk({tag, ".lstb_cnt"}, lstb_cnt, e_l);
        chk({tag, ".wstb_cnt"}, wstb_cnt, e_w);
    endtask

    task automatic set_key(input int k);
        kr = k / 4;
        kc = k % 4;
    endtask

    task automatic press(input int k, input string tag);
        set_key(k);
        pressed = 1'b1;
        cyc(40);
        pressed = 1'b0;
        cyc(40);
        m_apply(k);
        check_state(tag);
    endtask

    initial begin
        nRst = 1'b1; enable = 1'b1; pressed = 1'b0; kr = 0; kc = 0;
        force_en = 1'b1; force_val = 4'b1000;
        m_clear(); m_letter = 8'h00; e_l = 0; e_w = 0;
        cyc(2);
        chk("rst.col", col, 4'b1000);
        chk("rst.strobes", {letter_strobe, word_strobe}, 2'b00);
        check_state("rst");

        nRst = 1'b0; force_en = 1'b0;
        @(negedge clk);
        chk("scan.col0", col, 4'b1000);
        for (int i = 1; i <= 4; i++) begin
            logic [3:0] ecol;
            ecol = 4'b1000 >> (i % 4);
            repeat (2) @(negedge clk);
            chk("scan.col", col, ecol);
        end
        cyc(4);

        // APPLE
        press(1, "a1");  press(12, "a*");
        press(8, "p1");  press(12, "p*");
        press(8, "p2");  press(12, "p*2");
        for (int i = 0; i < 3; i++) press(5, "l");
        press(12, "l*");
        press(2, "e"); press(2, "e"); press(12, "e*");
        press(14, "word");

        // wrap on a four-letter key, then switch keys
        for (int i = 0; i < 5; i++) press(8, "wrap");
        press(1, "switch"); press(12, "switch*");

        // bounce: short press, one-cycle gap, then stable
        set_key(1);
        pressed = 1'b1; cyc(4);
        pressed = 1'b0; cyc(1);
        pressed = 1'b1; cyc(40);
        pressed = 1'b0; cyc(40);
        m_apply(1);
        check_state("bounce");
        set_key(2);
        pressed = 1'b1; cyc(3);
        pressed = 1'b0; cyc(60);
        check_state("glitch");
        press(13, "cancel0");

        // edge keys
        press(12, "star_empty");
        press(4, "h"); press(4, "h"); press(13, "cancel");
        press(15, "keyD"); press(3, "keyA");

        // enable dropped mid-press
        press(1, "en_pre");
        set_key(2);
        pressed = 1'b1; cyc(12);
        enable = 1'b0; cyc(2);
        m_clear();
        chk("en.col", col, 4'b1000);
        check_state("en_off");
        pressed = 1'b0; cyc(2);
        set_key(12);
        pressed = 1'b1; cyc(30);
        pressed = 1'b0; cyc(5);
        chk("en.no_strobe", lstb_cnt, e_l);
        enable = 1'b1; cyc(40);
        check_state("en_on");

        // reset while a key is held
        press(6, "m");
        set_key(12);
        pressed = 1'b1; cyc(40);
        m_apply(12);
        chk("held.strobe", lstb_cnt, e_l);
        nRst = 1'b1; pressed = 1'b0; cyc(2);
        m_clear(); m_letter = 8'h00;
        chk("held.rst_col", col, 4'b1000);
        nRst = 1'b0; cyc(60);
        check_state("held.rst");

        // randomized key stream
        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                enable = 1'b0; cyc(3);
                enable = 1'b1; cyc(2);
                m_clear();
            end
            press(k, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
